// File: rtl/fsm_chk_pkg.sv
// fsm_chk_pkg: shared state encoding for the fsm_counter stream checker
package fsm_chk_pkg;
    localparam int S_LOCK_W = 2;
    typedef enum logic [S_LOCK_W-1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;
endpackage

// File: rtl/fsm_count_checker_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    output logic [ERRW-1:0] q
);
    // count up on inc, hold once saturated
    always_ff @(posedge clk)
        if (!rst_n) q <= '0;
        else if (inc && q != '1) q <= q + ERRW'(1);
endmodule

// File: rtl/fsm_count_checker.sv
// fsm_count_checker: locks onto an incrementing count stream and flags out-of-sequence samples (optional CHK_ERR_CAPTURE_EN captures the first locked mismatch)
module fsm_count_checker
    import fsm_chk_pkg::*;
#(
    parameter int W        = 3,
    parameter int MAX_VAL  = 7,
    parameter int LOCK_CNT = 4,
    parameter int ERRW     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sample_en,
    input  logic [W-1:0]    count_in,
    output logic            locked,
    output logic            err_pulse,
    output logic            wrap_pulse,
    output logic [ERRW-1:0] err_count,
    output logic [W-1:0]    expected
`ifdef CHK_ERR_CAPTURE_EN
    ,
    output logic [W-1:0]    err_got,
    output logic [W-1:0]    err_exp
`endif
);
    localparam int SW = $clog2(LOCK_CNT + 1);
    localparam logic [W-1:0] MAXV = W'(MAX_VAL);

    state_t        state, state_n;
    logic [SW-1:0] streak, streak_n;
    logic          err_n, wrap_n;
    logic          legal, good;
    logic [W-1:0]  exp_n;

    assign legal  = count_in <= MAXV;
    assign good   = count_in == expected;
    assign exp_n  = (!legal || count_in == MAXV) ? '0 : count_in + W'(1);
    assign locked = state == S_LOCK;

    // next state, streak and pulses; a bad sample restarts the streak at itself when legal
    always_comb begin
        state_n  = state;
        streak_n = streak;
        err_n    = 1'b0;
        wrap_n   = 1'b0;
        if (sample_en) begin
            if (state == S_IDLE) begin
                state_n  = legal ? S_ACQ : S_IDLE;
                streak_n = legal ? SW'(1) : '0;
            end else if (good) begin
                streak_n = streak + SW'(1);
                state_n  = (state == S_LOCK || int'(streak) + 1 >= LOCK_CNT) ? S_LOCK : S_ACQ;
                wrap_n   = state == S_LOCK && count_in == '0;
            end else begin
                state_n  = S_ACQ;
                streak_n = legal ? SW'(1) : '0;
                err_n    = state == S_LOCK;
            end
        end
    end

    // state, prediction and pulse registers; prediction only moves on samples
    always_ff @(posedge clk)
        if (!rst_n) begin
            state      <= S_IDLE;
            streak     <= '0;
            expected   <= '0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            streak     <= streak_n;
            expected   <= sample_en ? exp_n : expected;
            err_pulse  <= err_n;
            wrap_pulse <= wrap_n;
        end

    sat_counter #(.ERRW(ERRW)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_n),
        .q     (err_count)
    );

`ifdef CHK_ERR_CAPTURE_EN
    logic captured;
    // freeze the first locked mismatch until reset
    always_ff @(posedge clk)
        if (!rst_n) begin
            captured <= 1'b0;
            err_got  <= '0;
            err_exp  <= '0;
        end else if (err_n && !captured) begin
            captured <= 1'b1;
            err_got  <= count_in;
            err_exp  <= expected;
        end
`endif
endmodule
